// File: rtl/dmem_sized.sv
// rtl/dmem_sized.sv - word-organised data memory with byte/half/word loads and stores
//
// Purpose: little-endian 32-bit data memory behind a valid/ready request port
// and a valid/ready response port. Latency is one cycle and throughput is one
// access per cycle. Misaligned, reserved-size and out-of-range requests are
// faulted; a faulted request still produces a response but never writes.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset (response state only, not memory)
//   req_valid  - request present
//   req_ready  - request can be accepted this cycle
//   req_write  - 1 = store, 0 = load
//   req_size   - 00 byte, 01 half, 10 word, 11 reserved (faults)
//   req_signed - sign-extend loads when 1
//   addr       - byte address
//   wdata      - right-aligned store data
//   rsp_valid  - response present
//   rsp_ready  - consumer accepts response
//   rsp_rdata  - extended load data, 0 for stores and faults
//   rsp_err    - request was faulted

module dmem_sized #(
  parameter int ADDR_BITS    = 12,
  parameter int INIT_PATTERN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << (ADDR_BITS - 2);

  localparam logic [31:0] INIT_W0 = (INIT_PATTERN != 0) ? 32'hDEADBEEF : 32'h0;
  localparam logic [31:0] INIT_W1 = (INIT_PATTERN != 0) ? 32'hCAFEBABE : 32'h0;
  localparam logic [31:0] INIT_W2 = (INIT_PATTERN != 0) ? 32'h12345678 : 32'h0;

  // Contents are defined from time zero and are deliberately outside the
  // reset domain so a reset never disturbs committed stores.
  logic [31:0] mem [DEPTH] = '{0: INIT_W0, 1: INIT_W1, 2: INIT_W2, default: 32'h0};

  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q,   rsp_err_d;

  logic                 accept;
  logic                 fault;
  logic                 range_fault;
  logic                 align_fault;
  logic [ADDR_BITS-3:0] word_idx;
  logic [31:0]          rd_word;
  logic [31:0]          rd_shift;
  logic [31:0]          load_data;
  logic [3:0]           wr_be;
  logic [31:0]          wr_data;

  // rst_n is folded in so nothing is accepted while reset is held.
  assign req_ready = rst_n & (~rsp_valid_q | rsp_ready);
  assign accept    = req_valid & req_ready;

  assign word_idx    = addr[ADDR_BITS-1:2];
  assign range_fault = (addr >> ADDR_BITS) != 32'd0;
  assign fault       = range_fault | align_fault;

  always_comb begin
    align_fault = 1'b0;
    case (req_size)
      2'b00:   align_fault = 1'b0;
      2'b01:   align_fault = addr[0];
      2'b10:   align_fault = (addr[1:0] != 2'b00);
      default: align_fault = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the lane enables alone pick
  // which bytes land.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = 32'h0;
    case (req_size)
      2'b00: begin
        wr_be   = 4'b0001 << addr[1:0];
        wr_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = 4'b0011 << addr[1:0];
        wr_data = {2{wdata[15:0]}};
      end
      2'b10: begin
        wr_be   = 4'b1111;
        wr_data = wdata;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_write && !fault) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) begin
          mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  // Combinational read so a load sees a store committed at the previous edge.
  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {addr[1:0], 3'b000};

  always_comb begin
    load_data = 32'h0;
    case (req_size)
      2'b00:   load_data = req_signed ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                      : {24'h0, rd_shift[7:0]};
      2'b01:   load_data = req_signed ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                      : {16'h0, rd_shift[15:0]};
      2'b10:   load_data = rd_word;
      default: load_data = 32'h0;
    endcase
  end

  // A new acceptance takes priority over retiring the held response, which
  // gives back-to-back throughput when the consumer is ready.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = fault;
      rsp_rdata_d = (fault || req_write) ? 32'h0 : load_data;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_sized.sv
// tb/tb_dmem_sized.sv - scoreboard bench for dmem_sized

module tb_dmem_sized;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_rd_q  [$];
  logic        exp_err_q [$];
  string       exp_nm_q  [$];

  dmem_sized #(.ADDR_BITS(12), .INIT_PATTERN(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .addr       (addr),
    .wdata      (wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Monitor: a response is consumed at the edge after a negedge where both
  // rsp_valid and rsp_ready are high.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rdata %08h err %0d expected none", rsp_rdata, rsp_err);
      end else begin
        string nm;
        logic [31:0] erd;
        logic        eerr;
        nm   = exp_nm_q.pop_front();
        erd  = exp_rd_q.pop_front();
        eerr = exp_err_q.pop_front();
        check({nm, "_rdata"}, rsp_rdata, erd);
        check({nm, "_err"}, {31'h0, rsp_err}, {31'h0, eerr});
      end
    end
  end

  // Present one request, wait (bounded) for acceptance, push its expectation.
  task automatic issue(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr);
    int n;
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    addr       = a;
    wdata      = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) begin
        exp_nm_q.push_back(nm);
        exp_rd_q.push_back(erd);
        exp_err_q.push_back(eerr);
        break;
      end
      n++;
      if (n > 20) begin
        total++;
        bad++;
        $display("FAIL %s_accept: got no acceptance expected acceptance within 20 cycles", nm);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    addr       = 32'h0;
    wdata      = 32'h0;
    rsp_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
    rst_n = 1'b1;

    // Basic loads from the preloaded pattern
    issue("lw0",   1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0);
    check("lw0_latency", {31'h0, rsp_valid}, 32'h1);
    issue("lb3s",  1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 32'hFFFFFFDE, 1'b0);
    issue("lbu3",  1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 32'h000000DE, 1'b0);
    issue("lh2s",  1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 32'hFFFFDEAD, 1'b0);
    issue("lhu0",  1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 32'h0000BEEF, 1'b0);
    issue("lb0s",  1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 32'hFFFFFFEF, 1'b0);
    issue("lbu1",  1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 32'h000000BE, 1'b0);

    // Store half then immediate load of the same word
    issue("sh6",   1'b1, 2'b01, 1'b0, 32'h6, 32'h1234ABCD, 32'h0, 1'b0);
    issue("lw4",   1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hABCDBABE, 1'b0);

    // Faults
    issue("lw2_mis",  1'b0, 2'b10, 1'b0, 32'h2,    32'h0, 32'h0, 1'b1);
    issue("sw_range", 1'b1, 2'b10, 1'b0, 32'h1000, 32'h55555555, 32'h0, 1'b1);
    issue("lw0_after",1'b0, 2'b10, 1'b0, 32'h0,    32'h0, 32'hDEADBEEF, 1'b1 ^ 1'b1);
    issue("lh1_mis",  1'b0, 2'b01, 1'b1, 32'h1,    32'h0, 32'h0, 1'b1);
    issue("rsvd_sz",  1'b0, 2'b11, 1'b0, 32'h0,    32'h0, 32'h0, 1'b1);
    issue("sb_rsvd",  1'b1, 2'b11, 1'b0, 32'h8,    32'hFFFFFFFF, 32'h0, 1'b1);

    // Byte store into word 2 and reads back
    issue("sb9",   1'b1, 2'b00, 1'b0, 32'h9, 32'h000000FF, 32'h0, 1'b0);
    issue("lw8",   1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h1234FF78, 1'b0);
    issue("lhuA",  1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 32'h00001234, 1'b0);
    drain();

    // Backpressure: response held for three cycles, queued request waits
    rsp_ready = 1'b0;
    issue("stall_a", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h1234FF78, 1'b0);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    addr       = 32'h4;
    repeat (3) begin
      @(negedge clk);
      check("stall_req_ready", {31'h0, req_ready}, 32'h0);
      check("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("stall_rsp_rdata", rsp_rdata, 32'h1234FF78);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    issue("stall_b", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hABCDBABE, 1'b0);
    check("stall_b_latency", {31'h0, rsp_valid}, 32'h1);
    drain();

    // Reset with a response pending; memory survives
    issue("sw_c", 1'b1, 2'b10, 1'b0, 32'hC, 32'hA5A5A5A5, 32'h0, 1'b0);
    drain();
    rsp_ready = 1'b0;
    issue("lw_c_drop", 1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 32'hA5A5A5A5, 1'b0);
    @(negedge clk);
    check("pend_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
    check("mid_rst_req_ready", {31'h0, req_ready}, 32'h0);
    void'(exp_nm_q.pop_front());
    void'(exp_rd_q.pop_front());
    void'(exp_err_q.pop_front());
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    issue("lw_c_post", 1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 32'hA5A5A5A5, 1'b0);
    issue("lw4_post",  1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hABCDBABE, 1'b0);
    issue("lw0_post",  1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0);
    drain();

    check("sb_empty", exp_rd_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_sized.md
DMEM_SIZED -- requirements
Module: dmem_sized

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 12, meaning the number of byte-address bits decoded; depth is 2^(ADDR_BITS-2) 32-bit words.
REQ-002 The block SHALL have parameter INIT_PATTERN, default 1, meaning preload of test words at time 0 (1 = preload, 0 = all zero).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1, request present.
REQ-006 The block SHALL have port req_ready, output, 1, request can be accepted this cycle.
REQ-007 The block SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-008 The block SHALL have port req_size, input, 2, access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-009 The block SHALL have port req_signed, input, 1, loads sign-extend when 1 and zero-extend when 0; ignored for stores and words.
REQ-010 The block SHALL have port addr, input, 32, byte address.
REQ-011 The block SHALL have port wdata, input, 32, store data right-aligned (byte in [7:0], half in [15:0]).
REQ-012 The block SHALL have port rsp_valid, output, 1, response present.
REQ-013 The block SHALL have port rsp_ready, input, 1, consumer accepts the response.
REQ-014 The block SHALL have port rsp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-015 The block SHALL have port rsp_err, output, 1, the request was faulted.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid = 1 and req_ready = 1.
REQ-017 req_ready SHALL equal (!rsp_valid | rsp_ready) and SHALL be 0 while rst_n = 0.
REQ-018 Memory SHALL be little-endian: byte lane k = addr[1:0] occupies word bits [8k+7:8k].
REQ-019 A request SHALL be faulted on any of: half access with addr[0] = 1; word access with addr[1:0] != 0; req_size = 11; any of addr[31:ADDR_BITS] != 0.
REQ-020 An accepted non-faulted store SHALL update only the addressed byte lanes at the accept edge; other lanes keep their value.
REQ-021 A faulted store SHALL leave memory unchanged.
REQ-022 An accepted load SHALL read the word at the accept edge, then select the addressed lane(s) and extend them per req_signed.
REQ-023 Every accepted request, load or store, SHALL produce exactly one response, with rsp_valid = 1 starting the cycle after acceptance (latency 1).
REQ-024 A response SHALL hold rsp_valid, rsp_rdata and rsp_err stable until the edge where rsp_ready = 1.
REQ-025 At the edge where rsp_ready = 1, rsp_valid SHALL be cleared unless a new request is accepted at the same edge, in which case the new response replaces it (full throughput, one access per cycle).
REQ-026 A load accepted the cycle after a store to the same word SHALL return the stored data, since the store commits at the earlier edge.
REQ-027 Faulted responses SHALL have rsp_err = 1 and rsp_rdata = 0; non-faulted responses SHALL have rsp_err = 0.
REQ-028 With INIT_PATTERN = 1, word 0 SHALL be 0xDEADBEEF, word 1 0xCAFEBABE, word 2 0x12345678, and all other words 0.

Reset
REQ-029 While rst_n = 0, the block SHALL force rsp_valid = 0, rsp_rdata = 0 and rsp_err = 0 immediately, without waiting for a clock edge.
REQ-030 Reset SHALL NOT alter memory contents; a store accepted before reset assertion stays committed.
REQ-031 A response pending when reset asserts SHALL be discarded.
REQ-032 No request SHALL be accepted during reset; the first acceptance is possible on the first rising edge with rst_n = 1.

Verification
REQ-033 The bench SHALL cover: reset release, then LW addr 0x0 -> next cycle rsp_valid = 1, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-034 The bench SHALL cover: LB addr 0x3 signed -> 0xFFFFFFDE; LBU addr 0x3 -> 0x000000DE; LH addr 0x2 signed -> 0xFFFFDEAD.
REQ-035 The bench SHALL cover: SH wdata 0x1234ABCD to addr 0x6, then LW addr 0x4 on the next cycle -> 0xABCDBABE.
REQ-036 The bench SHALL cover: LW addr 0x2 -> rsp_err = 1, rsp_rdata = 0; SW addr 0x1000 (ADDR_BITS = 12) -> rsp_err = 1, and no word changes (re-read word 0 = 0xDEADBEEF).
REQ-037 The bench SHALL cover: hold rsp_ready = 0 for 3 cycles with a response pending -> req_ready = 0 and outputs stable; then assert rsp_ready -> the queued request is accepted the same edge and its response follows one cycle later.
REQ-038 The bench SHALL cover: assert rst_n = 0 mid-cycle with rsp_valid = 1 -> rsp_valid = 0 before the next edge, and memory is unchanged after release.
